multi_score_accum: RTL and testbench

- Parametrised successor of the two-button score register for the Blast game.
- Accepts one 2-bit result code per channel for NUM_CH channels and scans the channels sequentially.
- Applies a generalised points rule with a saturating add.
- Keeps a best-score register across rounds, and reports busy/done so the game FSM can sequence round updates.

---
 rtl/blast_pkg.sv | 26 ++
 rtl/sat_add.sv | 17 +
 rtl/multi_score_accum.sv | 109 ++++++++++
 tb/tb_multi_score_accum.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blast_pkg.sv
// Shared definitions for the Blast score path: result codes, scan FSM states,
// and the points rule used by the score accumulator.
package blast_pkg;

    localparam logic [1:0] CODE_MISS = 2'd0;
    localparam logic [1:0] CODE_HIT  = 2'd1;
    localparam logic [1:0] CODE_VOID = 2'd2;

    typedef enum logic [1:0] {IDLE, SCAN, ADD} state_t;

    // Checked in order: no hits, all hits, every non-void hit, otherwise per-hit.
    function automatic int unsigned calc_points(
        input int unsigned h,
        input int unsigned v,
        input int unsigned num_ch,
        input int unsigned hit_pts,
        input int unsigned bonus_pts,
        input int unsigned all_hit_pts
    );
        if (h == 0)                       return 0;
        if (h == num_ch)                  return all_hit_pts;
        if (v > 0 && h == num_ch - v)     return bonus_pts;
        return h * hit_pts;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
module sat_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[W] ? '1 : sum[W-1:0];
    end

endmodule

// File: rtl/multi_score_accum.sv
// Multi-channel score accumulator: scans NUM_CH latched result codes one per
// cycle, adds the round's points with saturation, and tracks the best score.
module multi_score_accum
    import blast_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned SCORE_W     = 11,
    parameter int unsigned INIT_SCORE  = 55,
    parameter int unsigned HIT_PTS     = 1,
    parameter int unsigned BONUS_PTS   = 5,
    parameter int unsigned ALL_HIT_PTS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*NUM_CH-1:0]   codes,
    input  logic                  start,
    input  logic                  round_end,
    output logic                  busy,
    output logic                  done,
    output logic [SCORE_W-1:0]    score,
    output logic [SCORE_W-1:0]    best
);

    localparam int unsigned CNT_W = $clog2(NUM_CH + 1);
    localparam int unsigned IDX_W = $clog2(NUM_CH);

    state_t              state, state_nxt;
    logic [2*NUM_CH-1:0] codes_q;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    h, v;
    logic                pend;
    logic [1:0]          cur_code;
    logic                last;
    logic [SCORE_W-1:0]  pts;
    logic [SCORE_W-1:0]  sum;

    assign cur_code = codes_q[2*idx +: 2];
    assign last     = (idx == IDX_W'(NUM_CH - 1));
    assign busy     = (state != IDLE);
    assign pts      = SCORE_W'(calc_points(32'(h), 32'(v), NUM_CH,
                                           HIT_PTS, BONUS_PTS, ALL_HIT_PTS));

    sat_add #(.W(SCORE_W)) u_sat_add (
        .a (score),
        .b (pts),
        .y (sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = ADD;
            ADD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score   <= SCORE_W'(INIT_SCORE);
            best    <= '0;
            done    <= 1'b0;
            pend    <= 1'b0;
            codes_q <= '0;
            idx     <= '0;
            h       <= '0;
            v       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Commit happens before any start in the same cycle is scored.
                    if (round_end || pend) begin
                        best  <= (score > best) ? score : best;
                        score <= SCORE_W'(INIT_SCORE);
                        pend  <= 1'b0;
                    end
                    if (start) begin
                        codes_q <= codes;
                        idx     <= '0;
                        h       <= '0;
                        v       <= '0;
                    end
                end
                SCAN: begin
                    if (round_end) pend <= 1'b1;
                    if (cur_code == CODE_HIT)       h <= h + 1'b1;
                    else if (cur_code != CODE_MISS) v <= v + 1'b1;
                    if (!last) idx <= idx + 1'b1;
                end
                ADD: begin
                    if (round_end) pend <= 1'b1;
                    score <= sum;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_score_accum.sv
// Bench for multi_score_accum: three configurations checked every cycle against
// a round-level model, plus directed rounds with hand-computed scores.
module tb_multi_score_accum;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] codes_a [3];
    logic       start_a [3];
    logic       re_a    [3];

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [10:0] score0, best0, score1, best1;
    logic [5:0]  score2, best2;

    multi_score_accum u_ch2 (
        .clk(clk), .rst(rst), .codes(codes_a[0][3:0]), .start(start_a[0]),
        .round_end(re_a[0]), .busy(busy0), .done(done0), .score(score0), .best(best0)
    );

    multi_score_accum #(.NUM_CH(4)) u_ch4 (
        .clk(clk), .rst(rst), .codes(codes_a[1]), .start(start_a[1]),
        .round_end(re_a[1]), .busy(busy1), .done(done1), .score(score1), .best(best1)
    );

    multi_score_accum #(.SCORE_W(6), .INIT_SCORE(60)) u_sat6 (
        .clk(clk), .rst(rst), .codes(codes_a[2][3:0]), .start(start_a[2]),
        .round_end(re_a[2]), .busy(busy2), .done(done2), .score(score2), .best(best2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- round-level reference model ----------------
    int m_nch  [3] = '{2, 4, 2};
    int m_max  [3] = '{2047, 2047, 63};
    int m_init [3] = '{55, 55, 60};
    int m_score[3] = '{55, 55, 60};
    int m_best [3] = '{0, 0, 0};
    int m_cnt  [3] = '{0, 0, 0};
    int m_pend [3] = '{0, 0, 0};
    int m_done [3] = '{0, 0, 0};
    int m_codes[3] = '{0, 0, 0};

    function automatic int rule_points(input int c, input int n);
        int nh = 0;
        int nv = 0;
        for (int k = 0; k < n; k++) begin
            int code = (c >> (2*k)) & 3;
            if (code == 1)      nh++;
            else if (code != 0) nv++;
        end
        if (nh == 0)                   return 0;
        if (nh == n)                   return 10;
        if (nv > 0 && nh + nv == n)    return 5;
        return nh;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_score[i] = m_init[i];
                m_best[i]  = 0;
                m_cnt[i]   = 0;
                m_pend[i]  = 0;
                m_done[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 0;
                if (m_cnt[i] == 0) begin
                    if (re_a[i] || m_pend[i] != 0) begin
                        if (m_score[i] > m_best[i]) m_best[i] = m_score[i];
                        m_score[i] = m_init[i];
                        m_pend[i]  = 0;
                    end
                    if (start_a[i]) begin
                        m_codes[i] = int'(codes_a[i]);
                        m_cnt[i]   = m_nch[i] + 1;
                    end
                end else begin
                    if (re_a[i]) m_pend[i] = 1;
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        int s;
                        s = m_score[i] + rule_points(m_codes[i], m_nch[i]);
                        m_score[i] = (s > m_max[i]) ? m_max[i] : s;
                        m_done[i]  = 1;
                    end
                end
            end
        end
    end

    function automatic int busy_of(input int i);
        return (i == 0) ? int'(busy0) : (i == 1) ? int'(busy1) : int'(busy2);
    endfunction
    function automatic int done_of(input int i);
        return (i == 0) ? int'(done0) : (i == 1) ? int'(done1) : int'(done2);
    endfunction
    function automatic int score_of(input int i);
        return (i == 0) ? int'(score0) : (i == 1) ? int'(score1) : int'(score2);
    endfunction
    function automatic int best_of(input int i);
        return (i == 0) ? int'(best0) : (i == 1) ? int'(best1) : int'(best2);
    endfunction

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cyc ch%0d busy", i),  busy_of(i),  int'(m_cnt[i] != 0));
            check($sformatf("cyc ch%0d done", i),  done_of(i),  m_done[i]);
            check($sformatf("cyc ch%0d score", i), score_of(i), m_score[i]);
            check($sformatf("cyc ch%0d best", i),  best_of(i),  m_best[i]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_round(input int i, input int c, input int exp_score, input string name);
        int lat   = 0;
        int nbusy = 0;
        @(negedge clk);
        codes_a[i] = 8'(c);
        start_a[i] = 1'b1;
        @(negedge clk);
        start_a[i] = 1'b0;
        codes_a[i] = 8'(~c);
        while (done_of(i) == 0 && lat < 20) begin
            if (busy_of(i) != 0) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, m_nch[i] + 1);
        check({name, " busy cycles"}, nbusy, m_nch[i] + 1);
        check({name, " score"}, score_of(i), exp_score);
    endtask

    task automatic pulse_re(input int i, input int exp_best, input int exp_score, input string name);
        @(negedge clk);
        re_a[i] = 1'b1;
        @(negedge clk);
        re_a[i] = 1'b0;
        check({name, " best"}, best_of(i), exp_best);
        check({name, " score"}, score_of(i), exp_score);
    endtask

    initial begin
        int t;
        int extra;
        for (int i = 0; i < 3; i++) begin
            codes_a[i] = '0;
            start_a[i] = 1'b0;
            re_a[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset score", int'(score0), 55);
        check("reset best", int'(best0), 0);
        check("reset busy", int'(busy0), 0);
        check("reset sat6 score", int'(score2), 60);

        // Two-channel legacy table.
        run_round(0, 'b0101, 65, "all hit");
        run_round(0, 'b1001, 70, "void+hit bonus");
        run_round(0, 'b0001, 71, "single hit");
        run_round(0, 'b0000, 71, "all miss");
        run_round(0, 'b1010, 71, "all void");

        pulse_re(0, 71, 55, "round_end idle");
        run_round(0, 'b0101, 65, "post-commit all hit");
        pulse_re(0, 71, 55, "round_end lower score");
        run_round(0, 'b0101, 65, "pre-concurrency");

        // start and round_end pulsed during SCAN.
        @(negedge clk);
        codes_a[0] = 8'b0101;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        start_a[0] = 1'b1;
        re_a[0]    = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        re_a[0]    = 1'b0;
        t = 0;
        while (done0 == 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("busy start+re done seen", int'(t < 10), 1);
        check("busy start+re score", int'(score0), 75);
        check("busy start+re best before commit", int'(best0), 71);
        @(negedge clk);
        check("pending commit best", int'(best0), 75);
        check("pending commit score", int'(score0), 55);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0) extra++;
        end
        check("ignored start no extra done", extra, 0);

        // round_end and start together in IDLE.
        @(negedge clk);
        codes_a[0] = 8'b0001;
        start_a[0] = 1'b1;
        re_a[0]    = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        re_a[0]    = 1'b0;
        check("same-cycle commit best", int'(best0), 75);
        t = 0;
        while (done0 == 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("same-cycle score", int'(score0), 56);

        // Four channels.
        run_round(1, 'b01011000, 57, "ch4 mixed");
        run_round(1, 'b01100111, 62, "ch4 bonus");

        // Saturation at 6 bits.
        run_round(2, 'b0101, 63, "sat first");
        run_round(2, 'b0101, 63, "sat hold");

        // Reset in the middle of a scan.
        @(negedge clk);
        codes_a[0] = 8'b0101;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid-scan reset score", int'(score0), 55);
        check("mid-scan reset best", int'(best0), 0);
        check("mid-scan reset busy", int'(busy0), 0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0) extra++;
        end
        check("no done after reset", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
